// File: rtl/pl_hazard_ctrl.sv
// pl_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Merges load-use detection, taken-branch flush and a data-memory wait FSM
// that freezes the whole pipeline while a memory-stage access is pending.
// Also keeps a stall-cycle counter and a sticky memory-timeout error flag.
module pl_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             DMemReady,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             DMemReq,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           state;
  logic [TW-1:0]    tmo_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_err;

  logic timeout_hit;
  logic dmem_req;
  logic mem_stall;
  logic lw_stall;

  // Memory handshake and hazard detection; reset kills any request at once.
  always_comb begin
    timeout_hit = (state == S_WAIT) && (tmo_cnt == TW'(TIMEOUT));
    if (reset) begin
      dmem_req = 1'b0;
    end else if (state == S_WAIT) begin
      dmem_req = 1'b1;
    end else begin
      dmem_req = MemAccessM;
    end
    mem_stall = dmem_req & ~DMemReady & ~timeout_hit;
    lw_stall  = ~reset & (ResultSrcE == 2'b01) & (RdE != 5'd0) &
                ((Rs1D == RdE) | (Rs2D == RdE));
  end

  // Pipeline controls: a memory stall freezes everything and masks flushes.
  always_comb begin
    if (reset) begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall | mem_stall;
      StallD = lw_stall | mem_stall;
      StallE = mem_stall;
      StallM = mem_stall;
      FlushD = PCSrcE & ~mem_stall;
      FlushE = (lw_stall | PCSrcE) & ~mem_stall;
      FlushW = mem_stall;
    end
    DMemReq  = dmem_req;
    MemErr   = mem_err;
    StallCnt = stall_cnt;
  end

  // Wait FSM, timeout counter, stall counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      stall_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (mem_stall) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (MemAccessM && !DMemReady) begin
            state   <= S_WAIT;
            tmo_cnt <= TW'(1);
          end
        end
        S_WAIT: begin
          if (DMemReady) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
          end else if (timeout_hit) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
            mem_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

endmodule
